adrv9001_enable_ctrl: RTL and testbench

Sequences the ADRV9001 channel enable pin from the PL enable request. It applies programmable enable-to-data and data-to-disable guard delays, and gates the 32-bit IQ AXI-Stream so that data only moves while the channel is fully active. It sits directly upstream of the AXIS monitor/ILA stage. It is the source of `adrv9001_enable`, the gated stream handshake, and the `enable_cnt`/`disable_cnt` event counters that the monitor captures.

---
 rtl/adrv9001_enable_ctrl.sv | 118 +++++++++++
 tb/tb_adrv9001_enable_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/adrv9001_enable_ctrl.sv
// ADRV9001 channel enable sequencer: guard-delayed enable pin drive plus
// IQ AXI-Stream gating so samples only move while the channel is fully active.
//
// state        | meaning
// IDLE         | enable pin low, stream blocked, waiting for pl_en
// ENABLE_WAIT  | pin high, counting enable-to-data guard; pl_en drop aborts
// ACTIVE       | pin high, stream passes through
// DISABLE_WAIT | pin high, counting data-to-disable guard; pl_en ignored
module adrv9001_enable_ctrl #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 pl_en,
  input  logic [CNT_WIDTH-1:0] enable_dly,
  input  logic [CNT_WIDTH-1:0] disable_dly,
  input  logic [31:0]          s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [31:0]          m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 adrv9001_enable,
  output logic                 active,
  output logic [CNT_WIDTH-1:0] enable_cnt,
  output logic [CNT_WIDTH-1:0] disable_cnt,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    ENABLE_WAIT  = 2'd1,
    ACTIVE       = 2'd2,
    DISABLE_WAIT = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] dly_cntr, dly_cntr_d;
  logic [CNT_WIDTH-1:0] dly_target, dly_target_d;
  logic [CNT_WIDTH-1:0] enable_cnt_q, disable_cnt_q;
  logic                 enable_q, active_q;
  logic                 enable_done, disable_done;

  always_comb begin
    state_d      = state_q;
    dly_cntr_d   = dly_cntr + 1'b1;
    dly_target_d = dly_target;
    enable_done  = 1'b0;
    disable_done = 1'b0;
    case (state_q)
      IDLE: begin
        dly_cntr_d = '0;
        if (pl_en) begin
          state_d      = ENABLE_WAIT;
          dly_target_d = enable_dly;
        end
      end
      ENABLE_WAIT: begin
        if (!pl_en) begin
          state_d      = DISABLE_WAIT;
          dly_target_d = disable_dly;
          dly_cntr_d   = '0;
        end else if (dly_cntr == dly_target) begin
          state_d     = ACTIVE;
          enable_done = 1'b1;
          dly_cntr_d  = '0;
        end
      end
      ACTIVE: begin
        dly_cntr_d = '0;
        if (!pl_en) begin
          state_d      = DISABLE_WAIT;
          dly_target_d = disable_dly;
        end
      end
      DISABLE_WAIT: begin
        if (dly_cntr == dly_target) begin
          state_d      = IDLE;
          disable_done = 1'b1;
          dly_cntr_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pin and active flag are registered from the next state so they change
  // on the same edge as the state itself.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      dly_cntr      <= '0;
      dly_target    <= '0;
      enable_cnt_q  <= '0;
      disable_cnt_q <= '0;
      enable_q      <= 1'b0;
      active_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dly_cntr   <= dly_cntr_d;
      dly_target <= dly_target_d;
      enable_q   <= (state_d != IDLE);
      active_q   <= (state_d == ACTIVE);
      if (enable_done)  enable_cnt_q  <= enable_cnt_q + 1'b1;
      if (disable_done) disable_cnt_q <= disable_cnt_q + 1'b1;
    end
  end

  assign m_axis_tdata    = s_axis_tdata;
  assign m_axis_tvalid   = s_axis_tvalid & active_q;
  assign s_axis_tready   = m_axis_tready & active_q;
  assign adrv9001_enable = enable_q;
  assign active          = active_q;
  assign enable_cnt      = enable_cnt_q;
  assign disable_cnt     = disable_cnt_q;
  assign state           = state_q;

endmodule

// File: tb/tb_adrv9001_enable_ctrl.sv
// Self-checking bench: randomized enable episodes against a timeline model,
// stream integrity scoreboard, reset behaviour and counter wrap (narrow instance).
module tb_adrv9001_enable_ctrl;
  localparam int W  = 16;
  localparam int W2 = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          pl_en;
  logic [W-1:0]  enable_dly, disable_dly;
  logic [31:0]   s_tdata, m_tdata;
  logic          s_tvalid, s_tready, m_tvalid, m_tready;
  logic          en_pin, act;
  logic [W-1:0]  en_cnt, dis_cnt;
  logic [1:0]    st;

  logic          pl_en2;
  logic [W2-1:0] ed2, dd2;
  logic [31:0]   s_tdata2, m_tdata2;
  logic          s_tvalid2, s_tready2, m_tvalid2, m_tready2;
  logic          en_pin2, act2;
  logic [W2-1:0] en_cnt2, dis_cnt2;
  logic [1:0]    st2;

  always #5 clk = ~clk;

  adrv9001_enable_ctrl #(.CNT_WIDTH(W)) dut (
    .clk(clk), .rstn(rstn), .pl_en(pl_en),
    .enable_dly(enable_dly), .disable_dly(disable_dly),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .adrv9001_enable(en_pin), .active(act),
    .enable_cnt(en_cnt), .disable_cnt(dis_cnt), .state(st)
  );

  adrv9001_enable_ctrl #(.CNT_WIDTH(W2)) dut2 (
    .clk(clk), .rstn(rstn), .pl_en(pl_en2),
    .enable_dly(ed2), .disable_dly(dd2),
    .s_axis_tdata(s_tdata2), .s_axis_tvalid(s_tvalid2), .s_axis_tready(s_tready2),
    .m_axis_tdata(m_tdata2), .m_axis_tvalid(m_tvalid2), .m_axis_tready(m_tready2),
    .adrv9001_enable(en_pin2), .active(act2),
    .enable_cnt(en_cnt2), .disable_cnt(dis_cnt2), .state(st2)
  );

  int          n_chk = 0, n_pass = 0;
  int          en_base = 0, dis_base = 0;
  int          beats_model = 0, beats_dut = 0;
  logic        act_prev = 1'b0;
  logic [31:0] src_val = 32'h0, sink_exp = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One enable request: pl_en sampled high at edges 0..H-1, low from edge H.
  // Expected behaviour after each edge t follows directly from the timeline.
  task automatic episode(input int e, input int h, input int d, input int post_en,
                         input int pv, input int pr);
    logic hs, act_m;
    int   st_m, enc_m, disc_m;
    for (int t = 0; t <= h + d + 3; t++) begin
      pl_en       = (t < h);
      enable_dly  = (t == 0) ? W'(e) : (post_en >= 0 ? W'(post_en) : W'($urandom));
      disable_dly = (t == h) ? W'(d) : W'($urandom);
      s_tvalid    = ($urandom_range(3) < pv);
      m_tready    = ($urandom_range(3) < pr);
      s_tdata     = src_val;
      #1;
      check("m_tvalid", {31'b0, m_tvalid}, {31'b0, s_tvalid & act_prev});
      check("s_tready", {31'b0, s_tready}, {31'b0, m_tready & act_prev});
      check("m_tdata", m_tdata, s_tdata);
      hs = s_tvalid && s_tready;
      if (m_tvalid && m_tready) begin
        check("beat_data", m_tdata, sink_exp);
        sink_exp++;
        beats_dut++;
      end
      if (s_tvalid && m_tready && act_prev) beats_model++;
      @(posedge clk);
      #1;
      if (hs) src_val++;
      act_m = (t >= e + 1) && (t <= h - 1);
      if (t < h)           st_m = (t < e + 1) ? 1 : 2;
      else if (t <= h + d) st_m = 3;
      else                 st_m = 0;
      enc_m  = en_base + (((h > e + 1) && (t >= e + 1)) ? 1 : 0);
      disc_m = dis_base + ((t >= h + d + 1) ? 1 : 0);
      check("enable_pin", {31'b0, en_pin}, {31'b0, t <= h + d});
      check("active", {31'b0, act}, {31'b0, act_m});
      check("state", {30'b0, st}, 32'(st_m));
      check("enable_cnt", {16'b0, en_cnt}, 32'(enc_m) & 32'hFFFF);
      check("disable_cnt", {16'b0, dis_cnt}, 32'(disc_m) & 32'hFFFF);
      act_prev = act_m;
    end
    if (h > e + 1) en_base++;
    dis_base++;
  endtask

  initial begin
    int b0, d0;
    rstn = 1'b0; pl_en = 1'b0; enable_dly = '0; disable_dly = '0;
    s_tdata = '0; s_tvalid = 1'b1; m_tready = 1'b1;
    pl_en2 = 1'b0; ed2 = '0; dd2 = '0;
    s_tdata2 = '0; s_tvalid2 = 1'b0; m_tready2 = 1'b0;
    #12;
    check("rst_state", {30'b0, st}, 32'd0);
    check("rst_enable", {31'b0, en_pin}, 32'd0);
    check("rst_active", {31'b0, act}, 32'd0);
    check("rst_tvalid", {31'b0, m_tvalid}, 32'd0);
    check("rst_tready", {31'b0, s_tready}, 32'd0);
    check("rst_counts", {en_cnt, dis_cnt}, 32'd0);
    rstn = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      check("idle_enable", {31'b0, en_pin}, 32'd0);
      check("idle_tvalid", {31'b0, m_tvalid}, 32'd0);
      check("idle_tready", {31'b0, s_tready}, 32'd0);
      check("idle_counts", {en_cnt, dis_cnt}, 32'd0);
    end

    episode(10, 100, 5, -1, 4, 4);
    b0 = beats_dut;
    episode(20, 8, 5, -1, 4, 4);
    check("abort_beats", 32'(beats_dut - b0), 32'd0);
    episode(10, 40, 2, 3, 4, 3);

    b0 = beats_dut; d0 = beats_model;
    episode(2, 2500, 4, -1, 3, 3);
    check("stream_beats", 32'(beats_dut - b0), 32'(beats_model - d0));
    check("stream_sink_src", sink_exp, src_val);

    for (int i = 0; i < 30; i++)
      episode($urandom_range(0, 12), $urandom_range(1, 30), $urandom_range(0, 12),
              -1, $urandom_range(0, 4), $urandom_range(0, 4));

    pl_en = 1'b1; enable_dly = '0; s_tvalid = 1'b1; m_tready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_reset_active", {31'b0, act}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("midrst_state", {30'b0, st}, 32'd0);
    check("midrst_enable", {31'b0, en_pin}, 32'd0);
    check("midrst_active", {31'b0, act}, 32'd0);
    check("midrst_tready", {31'b0, s_tready}, 32'd0);
    check("midrst_tvalid", {31'b0, m_tvalid}, 32'd0);
    check("midrst_counts", {en_cnt, dis_cnt}, 32'd0);
    pl_en = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    en_base = 0; dis_base = 0; act_prev = 1'b0;

    // Narrow instance: 17 back-to-back sequences with pl_en re-asserted during
    // DISABLE_WAIT; counters wrap at 16 and the pin is low for one cycle.
    for (int s = 0; s < 17; s++) begin
      for (int p = 0; p < 4; p++) begin
        pl_en2 = (p != 2);
        @(posedge clk); #1;
        check("wrap_enable", {31'b0, en_pin2}, {31'b0, p != 3});
        check("wrap_state", {30'b0, st2}, 32'((p + 1) % 4));
        check("wrap_enable_cnt", {28'b0, en_cnt2}, 32'((s + (p >= 1 ? 1 : 0)) % 16));
        check("wrap_disable_cnt", {28'b0, dis_cnt2}, 32'((s + (p >= 3 ? 1 : 0)) % 16));
      end
    end
    pl_en2 = 1'b0;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
